// File: rtl/adxl362_spi_master.sv
// adxl362_spi_master
//   SPI mode 0 host controller for ADXL362 register access. Issues a write
//   (0x0A) or read (0x0B) command, the register address, then one write data
//   byte or 1..MAX_LEN read data bytes, all in one chip-select window.
//
// Ports:
//   clk_16mhz        system clock
//   reset            asynchronous reset, active-high
//   start            transaction request, accepted only while idle
//   rw               1 = read, 0 = write
//   address[5:0]     register address
//   length[3:0]      read byte count (0 means 1), ignored for writes
//   data_write[7:0]  write data byte, latched at start
//   data_read[7:0]   most recently received read byte
//   data_read_valid  one-cycle strobe per received read byte
//   busy             transaction in progress
//   done             one-cycle pulse at end of transaction
//   cs_n/sclk/mosi   SPI outputs (CPOL=0, MSB first)
//   miso             SPI data in
module adxl362_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 15
) (
  input  logic       clk_16mhz,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [5:0] address,
  input  logic [3:0] length,
  input  logic [7:0] data_write,
  output logic [7:0] data_read,
  output logic       data_read_valid,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int BYTE_W = $clog2(MAX_LEN + 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_CS_GAP
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div;
  logic [2:0]        r_bit;
  logic [BYTE_W-1:0] r_byte;
  logic [BYTE_W-1:0] r_last;
  logic              r_rw;
  logic [5:0]        r_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_tx;
  logic [6:0]        r_rx;
  logic [7:0]        r_data_read;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_cs_n;
  logic              r_sclk;

  logic              w_div_end;
  logic [7:0]        w_next_byte;
  logic [7:0]        w_cmd;

  assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_cmd     = rw ? 8'h0B : 8'h0A;

  // Byte loaded after the current one: address follows the command, then
  // write data (writes) or zero fill (reads).
  always_comb begin
    w_next_byte = '0;
    if (r_byte == '0)
      w_next_byte = {2'b00, r_addr};
    else if (!r_rw)
      w_next_byte = r_wdata;
  end

  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_last      <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_data_read <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_sclk      <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      if (r_state != S_IDLE)
        r_div <= w_div_end ? '0 : r_div + DIV_W'(1);

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rw    <= rw;
            r_addr  <= address;
            r_wdata <= data_write;
            // r_last is the index of the final byte: 1 + n
            if (!rw)
              r_last <= BYTE_W'(2);
            else if (length == 4'd0)
              r_last <= BYTE_W'(2);
            else
              r_last <= BYTE_W'(length) + BYTE_W'(1);
            r_div   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_tx    <= w_cmd;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CS_SETUP;
          end
        end

        S_CS_SETUP: begin
          if (w_div_end)
            r_state <= S_SHIFT;
        end

        S_SHIFT: begin
          if (w_div_end) begin
            if (!r_sclk) begin
              // Rising edge: sample miso.
              r_sclk <= 1'b1;
              r_rx   <= {r_rx[5:0], miso};
              if (r_rw && (r_bit == 3'd7) && (r_byte >= BYTE_W'(2))) begin
                r_data_read <= {r_rx, miso};
                r_valid     <= 1'b1;
              end
            end else begin
              // Falling edge: advance mosi to the next bit or byte.
              r_sclk <= 1'b0;
              if (r_bit == 3'd7) begin
                r_bit <= '0;
                if (r_byte == r_last) begin
                  r_state <= S_CS_HOLD;
                end else begin
                  r_byte <= r_byte + BYTE_W'(1);
                  r_tx   <= w_next_byte;
                end
              end else begin
                r_bit <= r_bit + 3'd1;
                r_tx  <= {r_tx[6:0], 1'b0};
              end
            end
          end
        end

        S_CS_HOLD: begin
          if (w_div_end) begin
            r_cs_n  <= 1'b1;
            r_tx    <= '0;
            r_state <= S_CS_GAP;
          end
        end

        S_CS_GAP: begin
          if (w_div_end) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_read       = r_data_read;
  assign data_read_valid = r_valid;
  assign busy            = r_busy;
  assign done            = r_done;
  assign cs_n            = r_cs_n;
  assign sclk            = r_sclk;
  assign mosi            = r_tx[7];

endmodule

// File: tb/tb_adxl362_spi_master.sv
// tb_adxl362_spi_master
//   Directed bench for adxl362_spi_master. Two instances (CLK_DIV=4 and
//   CLK_DIV=2) share a small ADXL362-like register slave through a bus mux.
module tb_adxl362_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, rw, sel;
  logic [5:0] address;
  logic [3:0] length;
  logic [7:0] data_write;
  logic       miso = 1'b0;

  logic       start_a, start_b;
  logic [7:0] dr_a, dr_b;
  logic       val_a, val_b, busy_a, busy_b, done_a, done_b;
  logic       cs_a, cs_b, sclk_a, sclk_b, mosi_a, mosi_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  adxl362_spi_master #(.CLK_DIV(4), .MAX_LEN(15)) u_dut_a (
    .clk_16mhz(clk), .reset(reset), .start(start_a), .rw(rw),
    .address(address), .length(length), .data_write(data_write),
    .data_read(dr_a), .data_read_valid(val_a), .busy(busy_a), .done(done_a),
    .cs_n(cs_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso)
  );

  adxl362_spi_master #(.CLK_DIV(2), .MAX_LEN(15)) u_dut_b (
    .clk_16mhz(clk), .reset(reset), .start(start_b), .rw(rw),
    .address(address), .length(length), .data_write(data_write),
    .data_read(dr_b), .data_read_valid(val_b), .busy(busy_b), .done(done_b),
    .cs_n(cs_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso)
  );

  logic       w_cs_n, w_sclk, w_mosi, w_busy, w_done, w_valid;
  logic [7:0] w_dr;
  assign w_cs_n  = sel ? cs_b   : cs_a;
  assign w_sclk  = sel ? sclk_b : sclk_a;
  assign w_mosi  = sel ? mosi_b : mosi_a;
  assign w_busy  = sel ? busy_b : busy_a;
  assign w_done  = sel ? done_b : done_a;
  assign w_valid = sel ? val_b  : val_a;
  assign w_dr    = sel ? dr_b   : dr_a;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave register model ----------------
  logic [7:0]  mem [0:63];
  int unsigned s_cnt = 0;
  int unsigned sclk_rise = 0;
  logic [7:0]  s_rx = '0, s_cmd = '0, s_tx = '0;
  logic [5:0]  s_addr = '0, s_wptr = '0, s_rptr = '0;
  logic [7:0]  mosi_q[$];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = 8'hAD;
    mem[1] = 8'h1D;
    mem[2] = 8'hF2;
    mem[3] = 8'h01;
  end

  always @(posedge w_sclk or negedge w_cs_n) begin
    if (!w_sclk) begin
      s_cnt = 0;
    end else begin
      sclk_rise++;
      s_rx = {s_rx[6:0], w_mosi};
      s_cnt++;
      if (s_cnt % 8 == 0) begin
        mosi_q.push_back(s_rx);
        if (s_cnt == 8) s_cmd = s_rx;
        else if (s_cnt == 16) begin
          s_addr = s_rx[5:0];
          s_wptr = s_rx[5:0];
        end else if (s_cmd == 8'h0A) begin
          mem[s_wptr] = s_rx;
          s_wptr++;
        end
      end
    end
  end

  always @(negedge w_sclk) begin
    if (s_cnt == 16) s_rptr = s_addr;
    if (s_cnt >= 16) begin
      if (s_cnt % 8 == 0) begin
        s_tx = mem[s_rptr];
        s_rptr++;
      end
      miso = s_tx[7 - (s_cnt % 8)];
    end
  end

  // ---------------- bus monitors ----------------
  int unsigned busy_cyc = 0, done_cnt = 0, cs_fall = 0;
  int unsigned mosi_viol = 0, sclk_viol = 0;
  int unsigned cyc = 0, last_rise = 0, sclk_per = 0;
  logic [7:0]  rd_q[$];
  logic        p_sclk = 1'b0, p_mosi = 1'b0, p_cs_n = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (w_busy) busy_cyc++;
    if (w_done) done_cnt++;
    if (w_valid) rd_q.push_back(w_dr);
    if (p_cs_n && !w_cs_n) cs_fall++;
    if (p_sclk && w_sclk && (p_mosi !== w_mosi)) mosi_viol++;
    if (w_cs_n && w_sclk) sclk_viol++;
    if (!p_sclk && w_sclk) begin
      sclk_per  = cyc - last_rise;
      last_rise = cyc;
    end
    p_sclk = w_sclk;
    p_mosi = w_mosi;
    p_cs_n = w_cs_n;
  end

  // ---------------- stimulus ----------------
  task automatic clear_mon;
    busy_cyc  = 0;
    done_cnt  = 0;
    cs_fall   = 0;
    sclk_rise = 0;
    rd_q.delete();
    mosi_q.delete();
  endtask

  task automatic wait_done;
    int unsigned i = 0;
    while (!w_done && i < 5000) begin
      @(negedge clk);
      i++;
    end
    check("done_timeout", (i < 5000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_txn(input logic s, input logic r, input logic [5:0] a,
                         input logic [3:0] l, input logic [7:0] wd, input bit extra);
    @(negedge clk);
    clear_mon();
    sel = s; rw = r; address = a; length = l; data_write = wd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (extra) begin
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    int unsigned i;
    reset = 1'b1; start = 1'b0; rw = 1'b0; sel = 1'b0;
    address = '0; length = '0; data_write = '0;
    repeat (3) @(negedge clk);
    check("rst_cs_n",  cs_a,   1);
    check("rst_sclk",  sclk_a, 0);
    check("rst_mosi",  mosi_a, 0);
    check("rst_busy",  busy_a, 0);
    check("rst_done",  done_a, 0);
    check("rst_valid", val_a,  0);
    check("rst_dr",    dr_a,   8'h00);
    check("rst_cs_b",  cs_b,   1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: read DEVID_AD
    run_txn(0, 1, 6'h00, 4'd1, 8'h00, 0);
    check("t1_busy", busy_cyc, 204);
    check("t1_done", done_cnt, 1);
    check("t1_edges", sclk_rise, 24);
    check("t1_per", sclk_per, 8);
    check("t1_nrd", rd_q.size(), 1);
    check("t1_rd", rd_q[0], 8'hAD);
    check("t1_nmosi", mosi_q.size(), 3);
    check("t1_mosi0", mosi_q[0], 8'h0B);
    check("t1_mosi1", mosi_q[1], 8'h00);
    check("t1_mosi2", mosi_q[2], 8'h00);

    // 2: write POWER_CTL then read back
    run_txn(0, 0, 6'h2D, 4'd5, 8'h02, 0);
    check("t2_wbusy", busy_cyc, 204);
    check("t2_wedges", sclk_rise, 24);
    check("t2_wnrd", rd_q.size(), 0);
    check("t2_wmosi0", mosi_q[0], 8'h0A);
    check("t2_wmosi1", mosi_q[1], 8'h2D);
    check("t2_wmosi2", mosi_q[2], 8'h02);
    run_txn(0, 1, 6'h2D, 4'd1, 8'h00, 0);
    check("t2_rmosi1", mosi_q[1], 8'h2D);
    check("t2_nrd", rd_q.size(), 1);
    check("t2_rd", rd_q[0], 8'h02);

    // 3: burst read of 4 bytes
    run_txn(0, 1, 6'h00, 4'd4, 8'h00, 0);
    check("t3_busy", busy_cyc, 396);
    check("t3_edges", sclk_rise, 48);
    check("t3_csfall", cs_fall, 1);
    check("t3_nrd", rd_q.size(), 4);
    check("t3_rd0", rd_q[0], 8'hAD);
    check("t3_rd1", rd_q[1], 8'h1D);
    check("t3_rd2", rd_q[2], 8'hF2);
    check("t3_rd3", rd_q[3], 8'h01);
    check("t3_mosi5", mosi_q[5], 8'h00);

    // 4: length 0 read with a start pulse while busy
    run_txn(0, 1, 6'h02, 4'd0, 8'h00, 1);
    repeat (50) @(negedge clk);
    check("t4_busy", busy_cyc, 204);
    check("t4_done", done_cnt, 1);
    check("t4_csfall", cs_fall, 1);
    check("t4_edges", sclk_rise, 24);
    check("t4_nrd", rd_q.size(), 1);
    check("t4_rd", rd_q[0], 8'hF2);
    check("t4_idle", w_busy, 0);

    // 5: reset at sclk edge 10
    @(negedge clk);
    clear_mon();
    sel = 1'b0; rw = 1'b1; address = 6'h00; length = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (sclk_rise < 10 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("t5_timeout", (i < 2000), 1);
    reset = 1'b1;
    #1;
    check("t5_cs_n", cs_a, 1);
    check("t5_sclk", sclk_a, 0);
    check("t5_busy", busy_a, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_nodone", done_cnt, 0);
    check("t5_nrd", rd_q.size(), 0);
    run_txn(0, 1, 6'h00, 4'd1, 8'h00, 0);
    check("t5_nrd2", rd_q.size(), 1);
    check("t5_rd", rd_q[0], 8'hAD);

    // 6: CLK_DIV=2 instance
    run_txn(1, 1, 6'h00, 4'd1, 8'h00, 0);
    check("t6_busy", busy_cyc, 102);
    check("t6_per", sclk_per, 4);
    check("t6_edges", sclk_rise, 24);
    check("t6_nrd", rd_q.size(), 1);
    check("t6_rd", rd_q[0], 8'hAD);

    check("mosi_stable", mosi_viol, 0);
    check("sclk_low_cs", sclk_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/adxl362_spi_master.md
Name: adxl362_spi_master

Overview:
Host-side SPI controller that issues ADXL362 register write (0x0A) and register read (0x0B) commands. It serializes one command, one address and one or more data bytes over a 4-wire SPI mode 0 link. It sits between system logic and the ADXL362 behavioral model (or the real part) on the PMOD header. Read data is returned one byte at a time, each byte with a valid strobe.

Parameters:
CLK_DIV, 4, clk_16mhz cycles per SCLK half-period. SCLK = 16 MHz / (2*CLK_DIV). Legal values are 2 and above.
MAX_LEN, 15, largest read burst length. The length input is 4 bits wide.

Ports:
clk_16mhz  input  1  system clock
reset  input  1  asynchronous reset, active-high
start  input  1  single-cycle request, sampled only while busy=0
rw  input  1  1=read (0x0B), 0=write (0x0A)
address  input  6  register address, sent on the wire as {2'b00,address}
length  input  4  number of read data bytes; 0 is treated as 1; ignored for writes
data_write  input  8  write data byte, latched at start
data_read  output  8  most recent received byte
data_read_valid  output  1  one-cycle strobe per received read byte
busy  output  1  high while a transaction is in progress
done  output  1  one-cycle pulse at the end of a transaction
cs_n  output  1  SPI chip select, active-low
sclk  output  1  SPI clock, CPOL=0
mosi  output  1  SPI data out, MSB first
miso  input  1  SPI data in

Behaviour:
- Reset, asynchronous and active-high, forces: cs_n=1, sclk=0, mosi=0, busy=0, done=0, data_read_valid=0, data_read=8'h00, state=IDLE. The bit, byte and divider counters clear.
- Reset asserted mid-transfer: cs_n rises and sclk drops immediately. No done pulse and no partial data_read_valid are produced.
- IDLE: when start=1 and busy=0, the block latches rw, address, data_write and n = (length==0 ? 1 : length). For writes, n is forced to 1.
  - busy rises on the next edge.
  - start is ignored whenever busy=1.
- State machine: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> CS_GAP -> IDLE.
- CS_SETUP (CLK_DIV cycles): cs_n=0, sclk=0, mosi = bit 7 of the command byte.
- SHIFT: sends 2+n bytes. Each bit takes 2*CLK_DIV cycles: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - miso is sampled on the cycle sclk rises.
  - mosi updates on the cycle sclk falls, so it is stable across every rising edge.
- Byte order on mosi:
  - Byte 0: command, 0x0B for read or 0x0A for write.
  - Byte 1: {2'b00,address}.
  - Remaining bytes: data_write for a write, 0x00 during read data bytes.
- miso bits are ignored during bytes 0 and 1, and during the data byte of a write.
- Read bytes: on the 8th sampled bit of each data byte, data_read is loaded with the assembled byte (MSB first). data_read_valid pulses on that same cycle and data_read holds until the next byte.
- After the final high phase, sclk returns low and the block enters CS_HOLD for CLK_DIV cycles with cs_n=0.
- CS_GAP: cs_n=1 for CLK_DIV cycles. This is the minimum deselect time.
  - The cycle after CS_GAP: done=1 for one cycle, busy falls on that same edge, state=IDLE.
  - A start may be accepted on the cycle after that.
- Timing: busy stays high for exactly CLK_DIV*(3+16*(2+n)) cycles.
  - There are exactly 8*(2+n) sclk rising edges per transaction.
  - sclk is 0 whenever cs_n=1.
- Burst reads rely on the slave's address auto-increment; the block does not re-send the address.
- Width rules:
  - The byte counter must hold 2+MAX_LEN = 17, so it is 5 bits wide.
  - The divider counter is clog2(CLK_DIV) bits wide and wraps to 0 at CLK_DIV-1.

Test Plan:
1. Read DEVID_AD: rw=1, address=0x00, length=1 -> mosi carries 0x0B, 0x00, 0x00; one data_read_valid with data_read=0xAD. With CLK_DIV=4, busy is high for 204 cycles and done pulses once.
2. Write then read POWER_CTL: write 0x02 to address 0x2D, then read 0x2D -> mosi on the write is 0x0A, 0x2D, 0x02; the read returns 0x02. Also check 24 sclk edges on the write.
3. Burst read: address 0x00, length=4 -> 4 strobes with data_read 0xAD, 0x1D, 0xF2, 0x01; 48 sclk edges; cs_n low continuously through all bytes.
4. length=0 read of 0x02 -> behaves as length=1 and returns 0xF2. A second start pulsed while busy -> ignored: exactly one done and no extra cs_n assertion.
5. Reset asserted at sclk edge 10 of a read -> same-cycle cs_n=1, sclk=0, busy=0, no done. A fresh read of 0x00 afterwards returns 0xAD.
6. CLK_DIV=2 build -> sclk period of 4 cycles; busy lasts 2*(3+48)=102 cycles for a single read. mosi never changes while sclk=1.
